mul_seq_ctrl: RTL and testbench

- Iterative unsigned shift-add multiplier controller for the 32-bit ALU datapath.
- Sequences one conditional add plus one right shift per clock over WIDTH cycles, producing a 2*WIDTH-bit product.
- The ALU top level instantiates it for the multiply opcode and uses the start/busy/done handshake.
- Contains its own operand register, product register, (WIDTH+1)-bit adder and iteration counter.

---
 rtl/mul_seq_ctrl.sv | 118 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Iterative unsigned shift-add multiplier with a start/busy/done handshake.
// Each CALC cycle does one conditional add of the multiplicand into the upper
// product half, then shifts the (WIDTH+1)-bit sum and the lower half right by one.
// After WIDTH iterations the product register holds the full 2*WIDTH-bit result.
module mul_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_accept;
   logic                 r_busy;
   logic                 r_done;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_mcand;
   logic [2*WIDTH-1:0]   r_product;
   logic [WIDTH:0]       w_sum;

   // Next-state decode; start is only honoured in IDLE and DONE.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_CALC;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (r_cnt == LAST_ITER) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_CALC;
            end
         end
         ST_DONE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_CALC;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Conditional add; the extra top bit keeps the carry for the shift.
   always_comb begin
      w_sum = {1'b0, r_product[2*WIDTH-1:WIDTH]};
      if (r_product[0]) begin
         w_sum = {1'b0, r_product[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
      end else begin
         w_sum = {1'b0, r_product[2*WIDTH-1:WIDTH]};
      end
   end

   // State register with busy/done registered alongside so they track the state exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_CALC);
         r_done  <= (w_state_nxt == ST_DONE);
      end
   end

   // Datapath: capture operands on accept, iterate in CALC, otherwise hold the result.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mcand   <= {WIDTH{1'b0}};
         r_product <= {(2*WIDTH){1'b0}};
         r_cnt     <= {CNT_W{1'b0}};
      end else if (w_accept) begin
         r_mcand   <= multiplicand;
         r_product <= {{WIDTH{1'b0}}, multiplier};
         r_cnt     <= {CNT_W{1'b0}};
      end else if (r_state == ST_CALC) begin
         r_product <= {w_sum, r_product[WIDTH-1:1]};
         r_cnt     <= r_cnt + CNT_W'(1);
      end else begin
         r_mcand   <= r_mcand;
         r_product <= r_product;
         r_cnt     <= r_cnt;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_product;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl: a vector table of operand pairs
// with hand-computed products, plus hand-written sequences for the handshake corners.
module tb_mul_seq_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        busy;
   logic        done;
   logic [63:0] product;

   int n_checks = 0;
   int n_errors = 0;

   mul_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Called at the negedge where start/operands were driven; the next posedge accepts.
   // Samples every negedge until done (bounded), changing operands mid-CALC.
   task automatic run_calc(input logic [63:0] exp, input string nm, input bit hold_start,
                           input logic [31:0] mid_a, input logic [31:0] mid_b);
      int  cyc    = 0;
      int  busy_n = 0;
      int  both_n = 0;
      bit  got    = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (busy && done) both_n++;
         if (busy) busy_n++;
         if (done) got = 1'b1;
         if (cyc == 1 && !hold_start) start = 1'b0;
         if (cyc == 3) begin
            multiplicand = mid_a;
            multiplier   = mid_b;
         end
      end
      chk({nm, "_done_seen"}, 64'(got), 64'd1);
      chk({nm, "_latency"}, 64'(cyc), 64'd33);
      chk({nm, "_busy_cycles"}, 64'(busy_n), 64'd32);
      chk({nm, "_busy_and_done"}, 64'(both_n), 64'd0);
      chk({nm, "_product"}, product, exp);
   endtask

   vec_t vecs [7];

   initial begin
      vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
      vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
      vecs[2] = '{32'h1234_5678,  32'h0000_0000,  64'h0000_0000_0000_0000};
      vecs[3] = '{32'h0000_0000,  32'hDEAD_BEEF,  64'h0000_0000_0000_0000};
      vecs[4] = '{32'h8000_0000,  32'h0000_0002,  64'h0000_0001_0000_0000};
      vecs[5] = '{32'hDEAD_BEEF,  32'h0000_0010,  64'h0000_000D_EADB_EEF0};
      vecs[6] = '{32'h0000_FFFF,  32'h0000_FFFF,  64'h0000_0000_FFFE_0001};

      reset = 1'b1;
      start = 1'b1;
      multiplicand = 32'd11;
      multiplier   = 32'd13;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_product", product, 64'd0);
      start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);

      // Table-driven products.
      for (int i = 0; i < 7; i++) begin
         multiplicand = vecs[i].a;
         multiplier   = vecs[i].b;
         start        = 1'b1;
         run_calc(vecs[i].exp, $sformatf("vec%0d", i), 1'b0, $urandom(), $urandom());
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse_end", i), 64'(done), 64'd0);
         chk($sformatf("vec%0d_idle_busy", i), 64'(busy), 64'd0);
         chk($sformatf("vec%0d_hold", i), product, vecs[i].exp);
      end

      // Start held high across CALC with operands changed: one operation only.
      multiplicand = 32'd7;
      multiplier   = 32'd6;
      start        = 1'b1;
      run_calc(64'd42, "hold_start", 1'b1, 32'd9, 32'd6);
      start = 1'b0;
      @(negedge clk);
      chk("hold_start_idle_busy", 64'(busy), 64'd0);
      chk("hold_start_idle_done", 64'(done), 64'd0);
      chk("hold_start_hold", product, 64'd42);

      // Back-to-back: new start during the DONE cycle.
      multiplicand = 32'd3;
      multiplier   = 32'd5;
      start        = 1'b1;
      run_calc(64'd15, "b2b_first", 1'b0, 32'd0, 32'd0);
      chk("b2b_prev_in_done", product, 64'd15);
      multiplicand = 32'h0001_0000;
      multiplier   = 32'h0001_0000;
      start        = 1'b1;
      run_calc(64'h0000_0001_0000_0000, "b2b_second", 1'b0, $urandom(), $urandom());
      start = 1'b0;
      @(negedge clk);
      chk("b2b_idle_done", 64'(done), 64'd0);

      // Reset asserted so it lands on iteration 10 of 100*200.
      multiplicand = 32'd100;
      multiplier   = 32'd200;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("abort_busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_product", product, 64'd0);
      begin
         int stray = 0;
         repeat (40) begin
            @(negedge clk);
            if (done || busy) stray++;
         end
         chk("abort_no_done", 64'(stray), 64'd0);
      end
      multiplicand = 32'd100;
      multiplier   = 32'd200;
      start        = 1'b1;
      run_calc(64'd20000, "after_abort", 1'b0, $urandom(), $urandom());

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
